// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand width, shift op select
// and the sequential shifter state encoding.
package alu_pkg;

  localparam int DATA_W = 32;

  localparam logic OP_SHL = 1'b0;
  localparam logic OP_ROL = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shl_step_unit.sv
// One shifter step: shift or rotate left by 0..STEP bits.
// Purely combinational; used once per SHIFT cycle.
module shl_step_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int STEP  = 1,
  parameter int S_W   = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] value,
  input  logic [S_W-1:0]   count,
  input  logic             op,
  output logic [WIDTH-1:0] result
);

  logic [WIDTH-1:0] shl_v;
  logic [WIDTH-1:0] fill_v;

  always_comb begin
    shl_v  = value << count;
    // A count of 0 shifts right by WIDTH, which yields 0.
    fill_v = value >> (WIDTH - int'(count));
    result = shl_v;
    if (op == OP_ROL) begin
      result = shl_v | fill_v;
    end
  end

endmodule

// File: rtl/shl_seq.sv
// Iterative left shifter/rotator: at most STEP bits per clock,
// start/busy/done handshake, registered outputs.
module shl_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int STEP  = 1,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] data_in,
  input  logic [AMT_W-1:0] amount,
  output logic [WIDTH-1:0] data_out,
  output logic             busy,
  output logic             done
);

  localparam int S_W = $clog2(STEP + 1);
  localparam logic [AMT_W-1:0] STEP_A = AMT_W'(STEP);

  state_t           state_q;
  state_t           state_d;
  logic [AMT_W-1:0] rem_q;
  logic [AMT_W-1:0] rem_d;
  logic [AMT_W-1:0] rem_next;
  logic             op_q;
  logic             op_d;
  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] step_v;
  logic             busy_d;
  logic             done_d;
  logic [S_W-1:0]   s;

  // s = min(STEP, remaining); remaining < STEP fits in S_W bits.
  assign s = (rem_q >= STEP_A) ? S_W'(STEP)
                               : rem_q[S_W-1:0];

  assign rem_next = rem_q - AMT_W'(s);

  shl_step_unit #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .S_W   (S_W)
  ) u_step (
    .value  (data_out),
    .count  (s),
    .op     (op_q),
    .result (step_v)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_out;
    rem_d   = rem_q;
    op_d    = op_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          data_d = data_in;
          rem_d  = amount;
          op_d   = op;
          if (amount != '0) begin
            state_d = ST_SHIFT;
            busy_d  = 1'b1;
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        data_d = step_v;
        rem_d  = rem_next;
        if (rem_next == '0) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          busy_d = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q  <= ST_IDLE;
      data_out <= '0;
      rem_q    <= '0;
      op_q     <= OP_SHL;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_out <= data_d;
      rem_q    <= rem_d;
      op_q     <= op_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

endmodule

// File: tb/tb_shl_seq.sv
// Randomized self-checking bench for shl_seq, STEP=1 and STEP=4
// instances driven in lockstep against a reference model.
module tb_shl_seq;

  logic        clock = 1'b0;
  logic        clear;
  logic        start;
  logic        op;
  logic [31:0] data_in;
  logic [4:0]  amount;
  logic [31:0] q1;
  logic [31:0] q4;
  logic        busy1;
  logic        busy4;
  logic        done1;
  logic        done4;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  shl_seq #(.WIDTH(32), .STEP(1)) dut1 (
    .clock    (clock),
    .clear    (clear),
    .start    (start),
    .op       (op),
    .data_in  (data_in),
    .amount   (amount),
    .data_out (q1),
    .busy     (busy1),
    .done     (done1)
  );

  shl_seq #(.WIDTH(32), .STEP(4)) dut4 (
    .clock    (clock),
    .clear    (clear),
    .start    (start),
    .op       (op),
    .data_in  (data_in),
    .amount   (amount),
    .data_out (q4),
    .busy     (busy4),
    .done     (done4)
  );

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Rotate = upper half of the doubled word shifted left.
  function automatic logic [31:0] ref_shift(logic o, logic [31:0] d, int a);
    logic [63:0] w;
    w = {d, d} << a;
    return o ? w[63:32] : (d << a);
  endfunction

  function automatic int ref_lat(int a, int step);
    return 1 + (a + step - 1) / step;
  endfunction

  task automatic run(logic o, logic [31:0] d, int a,
                     int poke_k, int clear_k);
    int l1;
    int l4;
    int kmax;
    logic [31:0] e;
    e    = ref_shift(o, d, a);
    l1   = ref_lat(a, 1);
    l4   = ref_lat(a, 4);
    kmax = ((l1 > l4) ? l1 : l4) + 1;
    @(negedge clock);
    start   = 1'b1;
    op      = o;
    data_in = d;
    amount  = a[4:0];
    @(posedge clock);
    #1;
    for (int k = 1; k <= kmax; k++) begin
      if (k > 1) begin
        @(posedge clock);
        #1;
      end
      start = 1'b0;
      chk($sformatf("busy1 a=%0d k=%0d", a, k), 32'(busy1), 32'(k < l1));
      chk($sformatf("done1 a=%0d k=%0d", a, k), 32'(done1), 32'(k == l1));
      chk($sformatf("busy4 a=%0d k=%0d", a, k), 32'(busy4), 32'(k < l4));
      chk($sformatf("done4 a=%0d k=%0d", a, k), 32'(done4), 32'(k == l4));
      if (k == l1) chk($sformatf("q1 op=%0d a=%0d", o, a), q1, e);
      if (k == l4) chk($sformatf("q4 op=%0d a=%0d", o, a), q4, e);
      if (k == poke_k) begin
        @(negedge clock);
        start   = 1'b1;
        op      = ~o;
        data_in = $urandom;
        amount  = 5'($urandom);
      end
      if (k == clear_k) begin
        @(negedge clock);
        clear = 1'b1;
        @(posedge clock);
        #1;
        clear = 1'b0;
        chk("clr q1", q1, 32'h0);
        chk("clr q4", q4, 32'h0);
        chk("clr busy", {30'b0, busy1, busy4}, 32'h0);
        chk("clr done", {30'b0, done1, done4}, 32'h0);
        break;
      end
    end
  endtask

  initial begin
    clear   = 1'b1;
    start   = 1'b0;
    op      = 1'b0;
    data_in = '0;
    amount  = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst q1", q1, 32'h0);
    chk("rst q4", q4, 32'h0);
    chk("rst busy1", 32'(busy1), 32'h0);
    chk("rst busy4", 32'(busy4), 32'h0);
    chk("rst done1", 32'(done1), 32'h0);
    chk("rst done4", 32'(done4), 32'h0);
    clear = 1'b0;

    run(1'b0, 32'h0000_0001, 31, 0, 0);
    chk("t1 literal", ref_shift(1'b0, 32'h1, 31), 32'h8000_0000);
    run(1'b1, 32'h8000_0001, 4, 0, 0);
    chk("t2 literal", ref_shift(1'b1, 32'h8000_0001, 4), 32'h0000_0018);
    run(1'b0, 32'h8000_0001, 4, 0, 0);
    run(1'b0, 32'hDEAD_BEEF, 0, 0, 0);
    run(1'b1, 32'hDEAD_BEEF, 0, 0, 0);
    run(1'b0, 32'h0000_00FF, 7, 0, 0);
    chk("t4 literal", ref_shift(1'b0, 32'hFF, 7), 32'h0000_7F80);
    run(1'b0, $urandom, 10, 3, 0);
    run(1'b1, $urandom, 13, 0, 0);
    run(1'b0, $urandom, 20, 0, 5);
    run(1'b1, $urandom, 9, 0, 0);
    run(1'b1, $urandom, 31, 0, 0);
    run(1'b1, $urandom, 1, 0, 0);
    for (int i = 0; i < 40; i++) begin
      run(1'($urandom), $urandom, int'($urandom_range(0, 31)), 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/shl_seq.md
Name: shl_seq

Overview:
Iterative left shifter/rotator, complementing the combinational arithmetic right shifter in the ALU datapath. It accepts a 32-bit operand, a shift amount and an op select, shifts by at most STEP bits per clock, and signals completion with a one-cycle done pulse. It sits beside the ALU and serves SHL/ROL instructions through a start/busy/done handshake with the control unit.

Parameters:
WIDTH, 32, operand/result width in bits.
STEP, 1, maximum bits shifted per clock; legal values are 1, 2, 4 and 8.
AMT_W, $clog2(WIDTH) (5), width of the shift amount.

Ports:
clock     input   1       single clock; everything updates on the rising edge.
clear     input   1       synchronous reset, active-high.
start     input   1       request a new operation; sampled only in IDLE.
op        input   1       0 = SHL (logical, zero fill), 1 = ROL (rotate left).
data_in   input   WIDTH   operand; captured when start is accepted.
amount    input   AMT_W   shift count 0..WIDTH-1; captured with data_in.
data_out  output  WIDTH   result register; valid when done=1, held until the next accepted start.
busy      output  1       high while the state is SHIFT.
done      output  1       one-cycle pulse when data_out holds the final result.

Behaviour:
- Interface (already decided): one clock, `clock`; reset `clear` is synchronous and active-high.
- Reset: on any edge where clear=1, state goes to IDLE and data_out=0, busy=0, done=0, remaining=0.
- clear has priority over all other inputs, including in the middle of an operation; the partial result is discarded.
- States are IDLE, SHIFT and DONE. All outputs are registered.
- IDLE: if start=1, capture data_in into data_out, capture amount into remaining and latch op.
  - Next state is SHIFT if amount != 0, otherwise DONE.
  - If start=0, stay in IDLE and hold data_out.
- SHIFT: each cycle, s = min(STEP, remaining).
  - data_out <= SHL: data_out << s. ROL: (data_out << s) | (data_out >> (WIDTH - s)).
  - remaining <= remaining - s.
  - When remaining - s == 0, next state is DONE.
- DONE: done=1 for exactly one cycle, busy=0, data_out holds the final value. Next state is IDLE unconditionally.
- Latency:
  - If start is sampled at the end of cycle N, done=1 in cycle N+1+ceil(amount/STEP).
  - amount=0 gives done in N+1 with data_out=data_in.
- start while busy or in DONE: ignored, with no queuing. A new start is accepted only in IDLE, the earliest being the cycle after done.
- Input changes while busy have no effect; the operands were captured at accept.
- data_out is undefined for the consumer while busy=1 (it shows intermediate values). Consumers must sample it on done.
- A rotate by WIDTH cannot occur because amount is at most WIDTH-1. The ROL fill term for s=0 is never evaluated because remaining>0 in SHIFT.

Decomposition:
- Shared package alu_pkg holds:
  - OP_SHL=1'b0 and OP_ROL=1'b1.
  - The state encoding: ST_IDLE, ST_SHIFT, ST_DONE (2 bits).
  - DATA_W=32.
- One combinational sub-module, shl_step_unit. It takes a WIDTH-bit value, a shift count s (0..STEP) and op, and returns the shifted or rotated value. shl_seq instantiates it once in the SHIFT datapath.

Test Plan:
1. Reset, then SHL data_in=32'h0000_0001, amount=31, STEP=1 -> busy high for 31 cycles, done in N+32, data_out=32'h8000_0000.
2. ROL data_in=32'h8000_0001, amount=4 -> done in N+5, data_out=32'h0000_0018. Repeat with SHL -> 32'h0000_0010.
3. amount=0, data_in=32'hDEAD_BEEF -> done in N+1 with data_out=32'hDEAD_BEEF, and busy never asserted.
4. STEP=4, SHL 32'h0000_00FF, amount=7 -> two SHIFT cycles (s=4, then s=3), done in N+3, data_out=32'h0000_7F80.
5. Start SHL amount=10, then pulse start with new operands at N+3 -> the second start is ignored. done occurs once in N+11 with the first result; a start at N+12 is then accepted.
6. Start SHL amount=20, then assert clear at N+5 -> next cycle data_out=0, busy=0, done=0, state IDLE. A subsequent start behaves normally.
